// File: rtl/game_pkg.sv
// Shared types and default timing constants for the snake game controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int TICK_DIV_D  = 25;
  localparam int MAX_SCORE_D = 50;
  localparam int OVER_HOLD_D = 200;
  localparam int BLINK_DIV_D = 25;

endpackage

// File: rtl/event_timer.sv
// Up-counter with a terminal flag; wraps at TERM-1 or saturates at TERM.
module event_timer #(
  parameter int W    = 8,
  parameter int TERM = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic wrap,
  output logic done
);

  localparam logic [W-1:0] LAST = W'(TERM - 1);
  localparam logic [W-1:0] TOP  = W'(TERM);

  logic [W-1:0] cnt;

  // Wrap mode flags the enabled cycle that rolls over; saturate mode is a level.
  always_comb begin
    if (wrap) done = en && (cnt == LAST);
    else      done = (cnt == TOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (wrap)             cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      else if (cnt != TOP)  cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Snake game sequencer: game FSM, move tick, score qualification and
// display mode/blink control. All outputs are registered.
module game_controller
  import game_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_D,
  parameter int MAX_SCORE = MAX_SCORE_D,
  parameter int OVER_HOLD = OVER_HOLD_D,
  parameter int BLINK_DIV = BLINK_DIV_D
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start,
  input  logic       pause,
  input  logic       goodColl,
  input  logic       badColl,
  output logic [1:0] state,
  output logic       moveTick,
  output logic       snakeReset,
  output logic       scoreInc,
  output logic       gameEnd,
  output logic [6:0] score,
  output logic       showHigh,
  output logic       blank
);

  localparam int TICK_W  = $clog2(TICK_DIV + 1);
  localparam int HOLD_W  = $clog2(OVER_HOLD + 1);
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  localparam logic [6:0] MAX = 7'(MAX_SCORE);

  state_t     state_q, state_n;
  logic [6:0] score_q, score_n;
  logic       inc_n, end_n, srst_n;
  logic       tick_tc, hold_tc, blink_tc;
  logic       tick_en, tick_clr, hold_en, blink_en;

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v >= MAX) ? MAX : v + 7'd1;
  endfunction

  // Tick only advances across PLAY->PLAY cycles, so a tick can never land
  // on the cycle that leaves PLAY and the count survives a pause intact.
  assign tick_en  = (state_q == PLAY) && (state_n == PLAY);
  assign tick_clr = (state_q == IDLE) || (state_q == OVER);
  assign hold_en  = (state_n == OVER);
  assign blink_en = (state_q == OVER);

  event_timer #(.W(TICK_W), .TERM(TICK_DIV)) u_tick (
    .clk(clk), .rst_n(nRst), .en(tick_en), .clr(tick_clr), .wrap(1'b1), .done(tick_tc)
  );

  // Hold counts the entry cycle too, so it equals cycles spent in OVER.
  event_timer #(.W(HOLD_W), .TERM(OVER_HOLD)) u_hold (
    .clk(clk), .rst_n(nRst), .en(hold_en), .clr(!hold_en), .wrap(1'b0), .done(hold_tc)
  );

  event_timer #(.W(BLINK_W), .TERM(BLINK_DIV)) u_blink (
    .clk(clk), .rst_n(nRst), .en(blink_en), .clr(!blink_en), .wrap(1'b1), .done(blink_tc)
  );

  always_comb begin
    state_n = state_q;
    score_n = score_q;
    inc_n   = 1'b0;
    end_n   = 1'b0;
    srst_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = PLAY;
          score_n = '0;
          srst_n  = 1'b1;
        end
      end
      PLAY: begin
        if (badColl || (score_q == MAX)) begin
          state_n = OVER;
          end_n   = 1'b1;
        end else begin
          if (pause) state_n = PAUSE;
          if (goodColl) begin
            inc_n   = 1'b1;
            score_n = sat_inc(score_q);
          end
        end
      end
      PAUSE: begin
        if (pause) state_n = PLAY;
      end
      OVER: begin
        if (start && hold_tc) begin
          state_n = PLAY;
          score_n = '0;
          srst_n  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      score_q    <= '0;
      moveTick   <= 1'b0;
      snakeReset <= 1'b0;
      scoreInc   <= 1'b0;
      gameEnd    <= 1'b0;
      showHigh   <= 1'b0;
      blank      <= 1'b0;
    end else begin
      state_q    <= state_n;
      score_q    <= score_n;
      moveTick   <= tick_tc;
      snakeReset <= srst_n;
      scoreInc   <= inc_n;
      gameEnd    <= end_n;
      showHigh   <= (state_n == OVER);
      if (state_n != OVER) blank <= 1'b0;
      else if (blink_tc)   blank <= ~blank;
    end
  end

  assign state = state_q;
  assign score = score_q;

endmodule

// File: tb/tb_game_controller.sv
// Randomized and directed bench for game_controller against a cycle-level
// reference model built from elapsed-cycle arithmetic.
module tb_game_controller;

  localparam int TD = 25;
  localparam int MS = 50;
  localparam int OH = 200;
  localparam int BD = 25;

  localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSE = 2, S_OVER = 3;

  logic       clk = 1'b0;
  logic       nRst, start, pause, goodColl, badColl;
  logic [1:0] state;
  logic       moveTick, snakeReset, scoreInc, gameEnd, showHigh, blank;
  logic [6:0] score;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state, score, PLAY cycles since (re)start, cycles in OVER.
  int m_st, m_score, m_played, m_oc;
  int e_tick, e_srst, e_inc, e_end;

  game_controller #(
    .TICK_DIV(TD), .MAX_SCORE(MS), .OVER_HOLD(OH), .BLINK_DIV(BD)
  ) dut (
    .clk(clk), .nRst(nRst), .start(start), .pause(pause),
    .goodColl(goodColl), .badColl(badColl), .state(state),
    .moveTick(moveTick), .snakeReset(snakeReset), .scoreInc(scoreInc),
    .gameEnd(gameEnd), .score(score), .showHigh(showHigh), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_score = 0; m_played = 0; m_oc = 0;
    e_tick = 0; e_srst = 0; e_inc = 0; e_end = 0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit gc, input bit bc);
    int ns;
    ns = m_st;
    e_tick = 0; e_srst = 0; e_inc = 0; e_end = 0;
    case (m_st)
      S_IDLE: if (st) begin ns = S_PLAY; m_score = 0; m_played = 0; e_srst = 1; end
      S_PLAY: begin
        if (bc || m_score == MS) begin
          ns = S_OVER; e_end = 1; m_oc = 0;
        end else begin
          if (pa) ns = S_PAUSE;
          if (gc) begin e_inc = 1; if (m_score < MS) m_score++; end
          if (ns == S_PLAY) begin
            m_played++;
            e_tick = ((m_played % TD) == 0) ? 1 : 0;
          end
        end
      end
      S_PAUSE: if (pa) ns = S_PLAY;
      default: if (st && m_oc >= OH) begin
        ns = S_PLAY; m_score = 0; m_played = 0; e_srst = 1;
      end
    endcase
    if (ns == S_OVER) m_oc++;
    m_st = ns;
  endtask

  task automatic chk_all();
    chk("state", int'(state), m_st);
    chk("moveTick", int'(moveTick), e_tick);
    chk("snakeReset", int'(snakeReset), e_srst);
    chk("scoreInc", int'(scoreInc), e_inc);
    chk("gameEnd", int'(gameEnd), e_end);
    chk("score", int'(score), m_score);
    chk("showHigh", int'(showHigh), (m_st == S_OVER) ? 1 : 0);
    chk("blank", int'(blank), (m_st == S_OVER) ? (((m_oc - 1) / BD) % 2) : 0);
  endtask

  task automatic cyc(input bit st, input bit pa, input bit gc, input bit bc);
    @(negedge clk);
    start = st; pause = pa; goodColl = gc; badColl = bc;
    @(posedge clk);
    if (nRst) model_step(st, pa, gc, bc);
    #1;
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  // Bounded search for the next moveTick; returns cycles waited or 0.
  task automatic tick_gap(output int gap);
    gap = 0;
    for (int k = 1; k <= 4 * TD && gap == 0; k++) begin
      cyc(0, 0, 0, 0);
      if (moveTick) gap = k;
    end
  endtask

  // Called on the first OVER cycle; probes the hold boundary, then restarts.
  task automatic over_restart();
    idle(99);
    cyc(1, 0, 0, 0);
    chk("start_at_100_ignored", int'(state), S_OVER);
    idle(98);
    cyc(1, 0, 0, 0);
    chk("start_at_199_ignored", int'(state), S_OVER);
    cyc(1, 0, 0, 0);
    chk("start_at_200_state", int'(state), S_PLAY);
    chk("start_at_200_snakeReset", int'(snakeReset), 1);
    chk("start_at_200_score", int'(score), 0);
  endtask

  initial begin
    int gap, ticks;
    nRst = 1'b0; start = 1'b0; pause = 1'b0; goodColl = 1'b0; badColl = 1'b0;
    model_reset();
    #1;
    chk_all();
    idle(3);
    @(negedge clk);
    nRst = 1'b1;

    cyc(1, 0, 0, 0);
    chk("start_snakeReset", int'(snakeReset), 1);
    tick_gap(gap);
    chk("first_tick_gap", gap, TD);
    tick_gap(gap);
    chk("second_tick_gap", gap, TD);

    // Pause 10 cycles into a period; collisions and start must be ignored.
    idle(10);
    cyc(0, 1, 0, 0);
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      cyc($urandom_range(9) == 0, 0, $urandom_range(3) == 0, $urandom_range(5) == 0);
      if (moveTick) ticks++;
    end
    chk("ticks_in_pause", ticks, 0);
    chk("state_in_pause", int'(state), S_PAUSE);
    cyc(0, 1, 0, 0);
    tick_gap(gap);
    chk("resume_tick_gap", gap, 15);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      idle(2);
    end
    chk("score_after_3", int'(score), 3);
    cyc(0, 0, 1, 1);
    chk("both_coll_gameEnd", int'(gameEnd), 1);
    chk("both_coll_scoreInc", int'(scoreInc), 0);
    chk("both_coll_score", int'(score), 3);
    over_restart();

    for (int i = 0; i < MS; i++) cyc(0, 0, 1, 0);
    chk("score_max", int'(score), MS);
    cyc(0, 0, 0, 0);
    chk("max_gameEnd", int'(gameEnd), 1);
    chk("max_state", int'(state), S_OVER);
    over_restart();

    // Asynchronous reset mid-period.
    idle(12);
    #2 nRst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_state", int'(state), S_IDLE);
    chk("async_rst_outputs",
        int'({moveTick, snakeReset, scoreInc, gameEnd, showHigh, blank}), 0);
    chk("async_rst_score", int'(score), 0);
    idle(2);
    @(negedge clk);
    nRst = 1'b1;

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(19) == 0, $urandom_range(29) == 0,
          $urandom_range(5) == 0, $urandom_range(59) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
